// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_load_ctrl
// Purpose  : Owns the single port of the instruction memory. Holds the fetch
//            stage stalled until a program image has been streamed in over a
//            valid/ready interface, then serves instruction fetches by turning
//            PC byte addresses into word addresses and flagging bad fetches.
// Revision : 1.0  initial release
// ============================================================================
module imem_load_ctrl #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // fetch side
  input  logic [WIDTH-1:0]     fetch_addr,
  output logic [WIDTH-1:0]     fetch_instr,
  output logic                 fetch_stall,
  output logic                 fetch_fault,
  // loader side
  input  logic                 ld_start,
  input  logic                 ld_valid,
  input  logic [WIDTH-1:0]     ld_data,
  input  logic                 ld_last,
  output logic                 ld_ready,
  output logic                 ld_done,
  output logic [ADDR_BITS:0]   ld_count,
  output logic                 ld_trunc,
  // memory side
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [WIDTH-1:0]     mem_wdata,
  input  logic [WIDTH-1:0]     mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  // Counter value while the final (DEPTH-th) memory word is being accepted
  localparam logic [ADDR_BITS:0] c_last_idx = (ADDR_BITS+1)'(DEPTH - 1);

  state_t                state_r;
  state_t                state_w;
  logic [ADDR_BITS:0]    r_count;
  logic                  r_done;
  logic                  r_trunc;
  logic                  r_fault;

  logic                  w_accept;
  logic                  w_full;
  logic                  w_fetch_bad;

  // A word is accepted only while LOAD presents ld_ready
  assign w_accept    = (state_r == LOAD) && ld_valid;
  // The accepted word fills the last free location
  assign w_full      = (r_count == c_last_idx);
  // Fetches must be word aligned and fall inside the memory
  assign w_fetch_bad = (fetch_addr[1:0] != 2'b00) ||
                       (fetch_addr[WIDTH-1:ADDR_BITS+2] != '0);

  assign ld_count    = r_count;
  assign ld_done     = r_done;
  assign ld_trunc    = r_trunc;
  assign fetch_fault = r_fault;
  assign mem_wdata   = ld_data;

  // State register plus load counter and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
      r_trunc <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      state_r <= state_w;
      r_done  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ld_start) begin
            r_count <= '0;
            r_trunc <= 1'b0;
            r_fault <= 1'b0;
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_count <= r_count + 1'b1;
            if (ld_last || w_full) begin
              r_done <= 1'b1;
            end
            if (!ld_last && w_full) begin
              r_trunc <= 1'b1;
            end
          end
        end
        RUN: begin
          // A reload clears the sticky fault even if this fetch is bad
          if (ld_start) begin
            r_count <= '0;
            r_trunc <= 1'b0;
            r_fault <= 1'b0;
          end else if (w_fetch_bad) begin
            r_fault <= 1'b1;
          end
        end
        default: begin
          r_count <= '0;
        end
      endcase
    end
  end

  // Next-state decode and per-state drive of the memory and fetch ports
  always_comb begin
    state_w     = state_r;
    ld_ready    = 1'b0;
    fetch_stall = 1'b1;
    fetch_instr = '0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    case (state_r)
      IDLE: begin
        if (ld_start) begin
          state_w = LOAD;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        mem_we   = w_accept;
        mem_addr = r_count[ADDR_BITS-1:0];
        if (w_accept && (ld_last || w_full)) begin
          state_w = RUN;
        end
      end
      RUN: begin
        fetch_stall = 1'b0;
        mem_addr    = fetch_addr[ADDR_BITS+1:2];
        fetch_instr = w_fetch_bad ? '0 : mem_rdata;
        if (ld_start) begin
          state_w = LOAD;
        end
      end
      default: begin
        state_w = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_load_ctrl
// Purpose  : Directed self-checking bench for imem_load_ctrl with a
//            behavioural 32-word memory (synchronous write, async read).
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        fetch_stall;
  logic        fetch_fault;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        ld_done;
  logic [5:0]  ld_count;
  logic        ld_trunc;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [32] = '{default: 32'h0};
  logic [4:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  int checks = 0;
  int errors = 0;

  imem_load_ctrl #(.WIDTH(32), .DEPTH(32), .ADDR_BITS(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_addr (fetch_addr),
    .fetch_instr(fetch_instr),
    .fetch_stall(fetch_stall),
    .fetch_fault(fetch_fault),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .ld_count   (ld_count),
    .ld_trunc   (ld_trunc),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural instruction memory with a log of every write
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  logic [31:0] prog [4] = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};
  logic        bp_valid [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        bp_last  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] bp_data  [3] = '{32'h000000B0, 32'h000000B3, 32'h000000B4};

  // Directed stimulus and checks
  initial begin
    int bad;
    int we_seen;
    rst_n = 1'b0; fetch_addr = '0; ld_start = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;

    // ---- reset then idle
    repeat (3) tick();
    check("rst_stall", fetch_stall, 1);
    check("rst_instr", fetch_instr, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_ready", ld_ready, 0);
    check("rst_done",  ld_done, 0);
    check("rst_count", ld_count, 0);
    check("rst_trunc", ld_trunc, 0);
    check("rst_we",    mem_we, 0);
    check("rst_addr",  mem_addr, 0);
    rst_n = 1'b1;
    ld_valid = 1'b1; ld_data = 32'hDEAD0000;  // stray data while idle must be ignored
    we_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_we || fetch_stall !== 1'b1 || fetch_instr !== 0) we_seen++;
    end
    check("idle_misbehave", we_seen, 0);
    check("idle_writes", wr_addr_q.size(), 0);
    check("idle_count", ld_count, 0);
    ld_valid = 1'b0;

    // ---- short load
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("sl_ready", ld_ready, 1);
    check("sl_stall", fetch_stall, 1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 3);
      #1;
      check($sformatf("sl_we%0d", i), mem_we, 1);
      check($sformatf("sl_addr%0d", i), mem_addr, i);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    #1;
    check("sl_done",  ld_done, 1);
    check("sl_stall_rel", fetch_stall, 0);
    check("sl_count", ld_count, 4);
    check("sl_trunc", ld_trunc, 0);
    check("sl_nwr",   wr_addr_q.size(), 4);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addr_q.size())
        if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== prog[i]) bad++;
    end
    check("sl_log", bad, 0);
    tick();
    check("sl_done_end", ld_done, 0);
    fetch_addr = 32'h8;
    #1;
    check("sl_fetch8", fetch_instr, 32'h01095020);

    // ---- backpressure (ld_last on an idle-valid cycle is ignored)
    fetch_addr = 32'h0;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("bp_stall", fetch_stall, 1);
    check("bp_ready", ld_ready, 1);
    check("bp_count0", ld_count, 0);
    clear_log();
    for (int k = 0; k < 5; k++) begin
      ld_valid = bp_valid[k]; ld_last = bp_last[k]; ld_data = 32'hB0 + k;
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("bp_done",  ld_done, 1);
    check("bp_count", ld_count, 3);
    check("bp_nwr",   wr_addr_q.size(), 3);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (i < wr_addr_q.size())
        if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== bp_data[i]) bad++;
    end
    check("bp_log", bad, 0);

    // ---- full memory, no ld_last: 33 words offered
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    clear_log();
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      ld_valid = 1'b1; ld_data = 32'h10000000 + i; ld_last = 1'b0;
      #1;
      if (ld_ready !== 1'b1) bad++;
      tick();
    end
    check("full_ready_during", bad, 0);
    ld_data = 32'h10000020;   // 33rd word still valid
    #1;
    check("full_ready33", ld_ready, 0);
    check("full_we33",    mem_we, 0);
    check("full_stall",   fetch_stall, 0);
    check("full_done",    ld_done, 1);
    check("full_trunc",   ld_trunc, 1);
    check("full_count",   ld_count, 32);
    tick();
    ld_valid = 1'b0;
    check("full_nwr", wr_addr_q.size(), 32);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] !== 5'(i) || wr_data_q[i] !== 32'h10000000 + i) bad++;
    end
    check("full_log", bad, 0);

    // ---- exact fit: ld_last on the 32nd word does not set ld_trunc
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ld_valid = 1'b1; ld_data = 32'h20000000 + i; ld_last = (i == 31);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("fit_done",  ld_done, 1);
    check("fit_trunc", ld_trunc, 0);
    check("fit_count", ld_count, 32);
    tick();

    // ---- faults in RUN
    fetch_addr = 32'h6;
    #1;
    check("flt_instr6", fetch_instr, 0);
    tick();
    check("flt_set", fetch_fault, 1);
    fetch_addr = 32'h80;
    #1;
    check("flt_instr80", fetch_instr, 0);
    tick();
    check("flt_hold1", fetch_fault, 1);
    fetch_addr = 32'h4;
    #1;
    check("flt_instr4", fetch_instr, 32'h20000001);
    tick();
    check("flt_hold2", fetch_fault, 1);

    // ---- reload from RUN, then reset mid-load
    ld_start = 1'b1;
    #1;
    check("rl_served", fetch_instr, 32'h20000001);
    tick();
    ld_start = 1'b0;
    check("rl_stall", fetch_stall, 1);
    check("rl_ready", ld_ready, 1);
    check("rl_fault", fetch_fault, 0);
    check("rl_count", ld_count, 0);
    check("rl_instr", fetch_instr, 0);
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 32'hAAAA0000 + i; ld_last = 1'b0;
      tick();
    end
    ld_valid = 1'b0;
    check("rl_count2", ld_count, 2);
    rst_n = 1'b0;
    tick();
    check("mr_ready", ld_ready, 0);
    check("mr_stall", fetch_stall, 1);
    check("mr_count", ld_count, 0);
    check("mr_we",    mem_we, 0);
    check("mr_mem0",  mem[0], 32'hAAAA0000);
    check("mr_mem1",  mem[1], 32'hAAAA0001);
    check("mr_mem2",  mem[2], 32'h20000002);
    rst_n = 1'b1;
    tick();
    check("mr_idle_ready", ld_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
